// File: rtl/lsu_mem_req_if.sv
// Bundle of the execute-side request/response channels and the memory-controller port.
// The slave modport is the load/store unit; the master modport is everything around it.
interface lsu_mem_req_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;

   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   logic        mem_valid;
   logic        mem_wen;
   logic [31:0] mem_raddr;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
      input  resp_ready, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask
   );

   modport master (
      output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
      output resp_ready, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/lsu_mem_req.sv
// Load/store front-end: one request at a time, word-aligned one-shot memory access,
// store lane shifting/masking and load byte/half extraction with sign/zero extension.
module lsu_mem_req #(
   parameter int unsigned LATENCY = 1
) (
   input  logic             clk,
   input  logic             reset,
   lsu_mem_req_if.slave     bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;

   logic        wen_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  size_q;
   logic        unsigned_q;
   logic        err_q;

   logic        accept;
   logic        reqErr;
   logic [1:0]  lane;
   logic [4:0]  laneShift;
   logic [31:0] shiftedRdata;
   logic [31:0] loadData;
   logic [3:0]  laneMask;
   logic        issue;
   logic        storeIssue;

   assign accept    = (state_q == IDLE) && bus.req_valid;
   assign reqErr    = (bus.req_size == 2'd3) ||
                      ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                      ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));
   assign lane      = addr_q[1:0];
   assign laneShift = {lane, 3'b000};

   // Request fields are frozen at acceptance so the memory and response sides never see requester changes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wen_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         size_q     <= '0;
         unsigned_q <= 1'b0;
         err_q      <= 1'b0;
      end else if (accept) begin
         wen_q      <= bus.req_wen;
         addr_q     <= bus.req_addr;
         wdata_q    <= bus.req_wdata;
         size_q     <= bus.req_size;
         unsigned_q <= bus.req_unsigned;
         err_q      <= reqErr;
      end
   end

   always_comb begin
      shiftedRdata = bus.mem_rdata >> laneShift;
      loadData     = shiftedRdata;
      case (size_q)
         2'd0:    loadData = unsigned_q ? {24'h0, shiftedRdata[7:0]}
                                        : {{24{shiftedRdata[7]}}, shiftedRdata[7:0]};
         2'd1:    loadData = unsigned_q ? {16'h0, shiftedRdata[15:0]}
                                        : {{16{shiftedRdata[15]}}, shiftedRdata[15:0]};
         default: loadData = shiftedRdata;
      endcase
   end

   // The counter holds the remaining ISSUE (load) or ISSUE+WAIT (store) cycles; zero means last cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               state_d = reqErr ? RESP : ISSUE;
               cnt_d   = CNT_INIT;
               rdata_d = '0;
            end
         end
         ISSUE: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
               if (!wen_q) rdata_d = loadData;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (wen_q) state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP: begin
            if (bus.resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      laneMask = 4'b1111;
      case (size_q)
         2'd0:    laneMask = 4'b0001 << lane;
         2'd1:    laneMask = 4'b0011 << lane;
         default: laneMask = 4'b1111;
      endcase
   end

   assign issue      = (state_q == ISSUE);
   assign storeIssue = issue && wen_q;

   // Write-side fields are forced to zero outside the store strobe so the DPI model never sees a stray write.
   assign bus.req_ready  = (state_q == IDLE);
   assign bus.mem_valid  = issue;
   assign bus.mem_wen    = storeIssue;
   assign bus.mem_raddr  = {addr_q[31:2], 2'b00};
   assign bus.mem_waddr  = {addr_q[31:2], 2'b00};
   assign bus.mem_wdata  = storeIssue ? (wdata_q << laneShift) : 32'h0;
   assign bus.mem_wmask  = storeIssue ? {4'h0, laneMask} : 8'h00;

   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_err   = (state_q == RESP) && err_q;
   assign bus.resp_rdata = (state_q == RESP) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_lsu_mem_req.sv
// Directed bench for lsu_mem_req: three instances (LATENCY 1, 3, 4) share one request stream
// and a word memory; the instance under test is chosen with sel and checked against hand-computed values.
module tb_lsu_mem_req;

   logic clk;
   logic reset;

   logic        reqValid;
   logic        reqWen;
   logic [31:0] reqAddr;
   logic [31:0] reqWdata;
   logic [1:0]  reqSize;
   logic        reqUnsigned;
   logic        respReady;

   logic [31:0] mem [0:511];

   lsu_mem_req_if busL1 ();
   lsu_mem_req_if busL3 ();
   lsu_mem_req_if busL4 ();

   lsu_mem_req #(.LATENCY(1)) dutL1 (.clk(clk), .reset(reset), .bus(busL1.slave));
   lsu_mem_req #(.LATENCY(3)) dutL3 (.clk(clk), .reset(reset), .bus(busL3.slave));
   lsu_mem_req #(.LATENCY(4)) dutL4 (.clk(clk), .reset(reset), .bus(busL4.slave));

   assign busL1.req_valid = reqValid;   assign busL3.req_valid = reqValid;   assign busL4.req_valid = reqValid;
   assign busL1.req_wen   = reqWen;     assign busL3.req_wen   = reqWen;     assign busL4.req_wen   = reqWen;
   assign busL1.req_addr  = reqAddr;    assign busL3.req_addr  = reqAddr;    assign busL4.req_addr  = reqAddr;
   assign busL1.req_wdata = reqWdata;   assign busL3.req_wdata = reqWdata;   assign busL4.req_wdata = reqWdata;
   assign busL1.req_size  = reqSize;    assign busL3.req_size  = reqSize;    assign busL4.req_size  = reqSize;
   assign busL1.req_unsigned = reqUnsigned;
   assign busL3.req_unsigned = reqUnsigned;
   assign busL4.req_unsigned = reqUnsigned;
   assign busL1.resp_ready = respReady; assign busL3.resp_ready = respReady; assign busL4.resp_ready = respReady;
   assign busL1.mem_rdata = mem[busL1.mem_raddr[10:2]];
   assign busL3.mem_rdata = mem[busL3.mem_raddr[10:2]];
   assign busL4.mem_rdata = mem[busL4.mem_raddr[10:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int sel;
   int curLat;
   logic        selReqReady, selRespValid, selRespErr, selMemValid, selMemWen;
   logic [31:0] selRespRdata, selMemRaddr, selMemWaddr, selMemWdata;
   logic [7:0]  selMemWmask;
   logic        allIdle;

   // Route the outputs of the instance under test onto one set of observation signals.
   always_comb begin
      selReqReady = busL1.req_ready;  selRespValid = busL1.resp_valid;
      selRespErr  = busL1.resp_err;   selRespRdata = busL1.resp_rdata;
      selMemValid = busL1.mem_valid;  selMemWen    = busL1.mem_wen;
      selMemRaddr = busL1.mem_raddr;  selMemWaddr  = busL1.mem_waddr;
      selMemWdata = busL1.mem_wdata;  selMemWmask  = busL1.mem_wmask;
      if (sel == 1) begin
         selReqReady = busL3.req_ready;  selRespValid = busL3.resp_valid;
         selRespErr  = busL3.resp_err;   selRespRdata = busL3.resp_rdata;
         selMemValid = busL3.mem_valid;  selMemWen    = busL3.mem_wen;
         selMemRaddr = busL3.mem_raddr;  selMemWaddr  = busL3.mem_waddr;
         selMemWdata = busL3.mem_wdata;  selMemWmask  = busL3.mem_wmask;
      end else if (sel == 2) begin
         selReqReady = busL4.req_ready;  selRespValid = busL4.resp_valid;
         selRespErr  = busL4.resp_err;   selRespRdata = busL4.resp_rdata;
         selMemValid = busL4.mem_valid;  selMemWen    = busL4.mem_wen;
         selMemRaddr = busL4.mem_raddr;  selMemWaddr  = busL4.mem_waddr;
         selMemWdata = busL4.mem_wdata;  selMemWmask  = busL4.mem_wmask;
      end
   end

   assign allIdle = busL1.req_ready && busL3.req_ready && busL4.req_ready;

   // Byte-masked memory write driven only by the instance under test.
   always @(posedge clk) begin
      if (selMemValid && selMemWen) begin
         for (int b = 0; b < 4; b++)
            if (selMemWmask[b]) mem[selMemWaddr[10:2]][8*b +: 8] <= selMemWdata[8*b +: 8];
      end
   end

   int vectors;
   int miscompares;

   int          gMemCycles, gFirstResp, gAddrBad, gStableBad, gReadyHigh;
   logic [31:0] gRdata, gWaddr, gWdata;
   logic [7:0]  gWmask;
   logic        gErr, gWen, gPostReady, gPostResp;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic waitAllIdle();
      for (int i = 0; i < 100 && !allIdle; i++) @(negedge clk);
      checkOutput("idleWait", 32'(allIdle), 32'd1);
   endtask

   // Issue one request, then follow it cycle by cycle until the response handshake.
   task automatic applyStimulus(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic uns, input int stall);
      int   cyc;
      int   stallSeen;
      logic done;
      logic [31:0] wordAddr;
      waitAllIdle();
      wordAddr   = addr & 32'hFFFF_FFFC;
      reqValid   = 1'b1;  reqWen = wen;  reqAddr = addr;  reqWdata = wdata;
      reqSize    = size;  reqUnsigned = uns;
      respReady  = (stall == 0);
      @(negedge clk);
      reqValid   = 1'b0;
      gMemCycles = 0; gFirstResp = 0; gAddrBad = 0; gStableBad = 0; gReadyHigh = 0;
      gRdata = '0; gErr = 1'b0; gWen = 1'b0; gWaddr = '0; gWdata = '0; gWmask = '0;
      cyc = 1; stallSeen = 0; done = 1'b0;
      while (!done && cyc <= 40) begin
         if (selReqReady) gReadyHigh++;
         if (selMemValid) begin
            gMemCycles++;
            if (selMemRaddr !== wordAddr) gAddrBad++;
            if (selMemWen) begin
               gWen = 1'b1; gWaddr = selMemWaddr; gWdata = selMemWdata; gWmask = selMemWmask;
            end
         end
         if (selRespValid) begin
            if (gFirstResp == 0) begin
               gFirstResp = cyc; gRdata = selRespRdata; gErr = selRespErr;
            end else if (selRespRdata !== gRdata || selRespErr !== gErr) begin
               gStableBad++;
            end
            if (respReady) done = 1'b1;
            else if (stallSeen == stall) begin
               respReady = 1'b1; done = 1'b1;
            end else stallSeen++;
         end
         if (!done) begin
            @(negedge clk);
            cyc++;
         end
      end
      checkOutput("respHandshake", 32'(done), 32'd1);
      @(negedge clk);
      gPostReady = selReqReady;
      gPostResp  = selRespValid;
      respReady  = 1'b1;
   endtask

   task automatic loadVector(input string tag, input logic [31:0] addr, input logic [1:0] size,
                             input logic uns, input logic [31:0] expData);
      applyStimulus(1'b0, addr, 32'h0, size, uns, 0);
      checkOutput({tag, ".memCycles"}, 32'(gMemCycles), 32'(curLat));
      checkOutput({tag, ".respCycle"}, 32'(gFirstResp), 32'(curLat + 1));
      checkOutput({tag, ".rdata"}, gRdata, expData);
      checkOutput({tag, ".err"}, 32'(gErr), 32'd0);
   endtask

   task automatic storeVector(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic [31:0] expWdata, input logic [7:0] expMask);
      applyStimulus(1'b1, addr, wdata, size, 1'b0, 0);
      checkOutput({tag, ".memCycles"}, 32'(gMemCycles), 32'd1);
      checkOutput({tag, ".wen"}, 32'(gWen), 32'd1);
      checkOutput({tag, ".waddr"}, gWaddr, addr & 32'hFFFF_FFFC);
      checkOutput({tag, ".wdata"}, gWdata, expWdata);
      checkOutput({tag, ".wmask"}, 32'(gWmask), 32'(expMask));
      checkOutput({tag, ".respCycle"}, 32'(gFirstResp), 32'(curLat + 1));
      checkOutput({tag, ".rdata"}, gRdata, 32'h0);
      checkOutput({tag, ".err"}, 32'(gErr), 32'd0);
   endtask

   task automatic errorVector(input string tag, input logic [31:0] addr, input logic [1:0] size);
      applyStimulus(1'b0, addr, 32'h0, size, 1'b0, 0);
      checkOutput({tag, ".memCycles"}, 32'(gMemCycles), 32'd0);
      checkOutput({tag, ".respCycle"}, 32'(gFirstResp), 32'd1);
      checkOutput({tag, ".err"}, 32'(gErr), 32'd1);
      checkOutput({tag, ".rdata"}, gRdata, 32'h0);
   endtask

   initial begin
      int respSeen;
      vectors = 0; miscompares = 0;
      sel = 0; curLat = 1;
      reqValid = 1'b0; reqWen = 1'b0; reqAddr = '0; reqWdata = '0; reqSize = '0; reqUnsigned = 1'b0;
      respReady = 1'b1;
      for (int i = 0; i < 512; i++) mem[i] = 32'h0;
      mem[32'h100 >> 2] = 32'h80FF_7F01;
      mem[32'h400 >> 2] = 32'hCAFE_F00D;

      reset = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("rst.reqReady",  32'(selReqReady),  32'd1);
      checkOutput("rst.memValid",  32'(selMemValid),  32'd0);
      checkOutput("rst.memWen",    32'(selMemWen),    32'd0);
      checkOutput("rst.memWdata",  selMemWdata,       32'h0);
      checkOutput("rst.memWmask",  32'(selMemWmask),  32'd0);
      checkOutput("rst.respValid", 32'(selRespValid), 32'd0);
      checkOutput("rst.respErr",   32'(selRespErr),   32'd0);
      checkOutput("rst.respRdata", selRespRdata,      32'h0);
      reset = 1'b0;
      @(negedge clk);

      // LATENCY=1 loads from word 0x80FF_7F01 at 0x100.
      loadVector("lb101",  32'h101, 2'd0, 1'b0, 32'h0000_007F);
      loadVector("lb102",  32'h102, 2'd0, 1'b0, 32'hFFFF_FFFF);
      loadVector("lbu103", 32'h103, 2'd0, 1'b1, 32'h0000_0080);
      loadVector("lh100",  32'h100, 2'd1, 1'b0, 32'h0000_7F01);
      loadVector("lh102",  32'h102, 2'd1, 1'b0, 32'hFFFF_80FF);
      loadVector("lhu102", 32'h102, 2'd1, 1'b1, 32'h0000_80FF);
      loadVector("lw100",  32'h100, 2'd2, 1'b0, 32'h80FF_7F01);

      // Stores and read-back through the same instance.
      storeVector("sh202", 32'h202, 32'h0000_BEEF, 2'd1, 32'hBEEF_0000, 8'h0C);
      loadVector("lw200a", 32'h200, 2'd2, 1'b0, 32'hBEEF_0000);
      storeVector("sb203", 32'h203, 32'h1234_5678, 2'd0, 32'h7800_0000, 8'h08);
      loadVector("lw200b", 32'h200, 2'd2, 1'b0, 32'h78EF_0000);

      // Misaligned and illegal-size requests never touch memory.
      errorVector("lw301",  32'h301, 2'd2);
      errorVector("size3",  32'h300, 2'd3);
      errorVector("lh101",  32'h101, 2'd1);

      // LATENCY=4: store timing, then a load with a three-cycle response stall.
      sel = 2; curLat = 4;
      storeVector("sw204", 32'h204, 32'hA5A5_1234, 2'd2, 32'hA5A5_1234, 8'h0F);
      applyStimulus(1'b0, 32'h400, 32'h0, 2'd2, 1'b0, 3);
      checkOutput("stall.memCycles", 32'(gMemCycles), 32'd4);
      checkOutput("stall.addrStable", 32'(gAddrBad), 32'd0);
      checkOutput("stall.respCycle", 32'(gFirstResp), 32'd5);
      checkOutput("stall.rdata", gRdata, 32'hCAFE_F00D);
      checkOutput("stall.respStable", 32'(gStableBad), 32'd0);
      checkOutput("stall.reqReadyLow", 32'(gReadyHigh), 32'd0);
      checkOutput("stall.postReady", 32'(gPostReady), 32'd1);
      checkOutput("stall.postResp", 32'(gPostResp), 32'd0);

      // LATENCY=3: reset lands in the second ISSUE cycle of a load.
      sel = 1; curLat = 3;
      waitAllIdle();
      reqValid = 1'b1; reqWen = 1'b0; reqAddr = 32'h100; reqSize = 2'd2; reqUnsigned = 1'b0;
      @(negedge clk);
      reqValid = 1'b0;
      checkOutput("abort.issue1", 32'(selMemValid), 32'd1);
      @(negedge clk);
      checkOutput("abort.issue2", 32'(selMemValid), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("abort.memValid", 32'(selMemValid), 32'd0);
      checkOutput("abort.reqReady", 32'(selReqReady), 32'd1);
      checkOutput("abort.respValid", 32'(selRespValid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      respSeen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (selRespValid || selMemValid) respSeen++;
      end
      checkOutput("abort.quiet", 32'(respSeen), 32'd0);
      loadVector("lw100L3", 32'h100, 2'd2, 1'b0, 32'h80FF_7F01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lsu_mem_req.md
# lsu_mem_req

Load/store front-end between the execute stage and the DPI-backed memory controller. It accepts one load or store request at a time over a valid/ready handshake and aligns the address to a word. It generates the byte write mask and lane-shifted store data, and drives the memory controller's combinational port with a clean one-shot access. For loads it captures the returned word, extracts the addressed byte or halfword, and sign- or zero-extends it. It then presents the result on a valid/ready response channel.

## Interface
- LATENCY, 1, number of cycles an access occupies the memory side before completion; legal range 1..15.

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal-size request; no memory access made
- mem_valid  out  1  memory access strobe
- mem_wen  out  1  write enable to memory
- mem_raddr  out  32  word-aligned read address (req_addr & ~3)
- mem_waddr  out  32  word-aligned write address (req_addr & ~3)
- mem_wdata  out  32  lane-shifted store data
- mem_wmask  out  8  byte mask; bits [7:4] always 0
- mem_rdata  in  32  word returned by memory; valid combinationally while mem_valid=1 and mem_wen=0

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP. All request fields are latched at acceptance. The mem_* and resp_* outputs are driven only from latched fields.
- **IDLE**
  - req_ready=1.
  - On req_valid, latch the request.
  - A request is an error when size==3, when size==1 with addr[0]=1, or when size==2 with addr[1:0]!=0. An error request goes to RESP with err=1.
  - Any other request goes to ISSUE.
- **ISSUE, load**
  - mem_valid=1 and mem_wen=0 for LATENCY consecutive cycles, with address stable throughout.
  - mem_rdata is captured on the last of these cycles, then the FSM goes to RESP.
- **ISSUE, store**
  - mem_valid=1 and mem_wen=1 for exactly one cycle.
  - If LATENCY>1 the FSM goes to WAIT for LATENCY-1 cycles with mem_valid=0; otherwise it goes to RESP.
- A 4-bit down-counter, loaded at acceptance, sequences the ISSUE and WAIT cycles.
- **RESP**
  - resp_valid=1 and is held with stable data until resp_ready=1.
  - The handshake cycle returns the FSM to IDLE. There is no bypass: the next request is accepted no earlier than the cycle after the response handshake.
- **Store lanes** (k=addr[1:0])
  - mem_wdata = req_wdata << 8k.
  - wmask = 0x1<<k for a byte, 0x3<<k for a half, 0xF for a word.
- **Load extract**
  - s = rdata >> 8k.
  - Byte result is s[7:0], extended from bit 7 unless unsigned.
  - Half result is s[15:0], extended from bit 15 unless unsigned.
  - Word result is s.
- When mem_valid=0, mem_wen, mem_wdata and mem_wmask are driven to 0. This prevents spurious DPI writes on input changes.
- **Reset** (asynchronous, active-high)
  - State goes to IDLE. mem_valid, mem_wen, mem_wmask, mem_wdata, resp_valid, resp_err and resp_rdata go to 0. req_ready=1.
  - Reset mid-access aborts with no response. If reset lands in the store's ISSUE cycle, the write may or may not have occurred.

## Timing
- The handshake occurs at the edge ending cycle N.
- Load: mem_valid is high in cycles N+1..N+LATENCY; resp_valid is first high in cycle N+LATENCY+1.
- Store: mem_valid is high in cycle N+1 only; resp_valid is first high in cycle N+LATENCY+1.
- Error: no mem_valid; resp_valid is first high in cycle N+1.
- Minimum request-to-request spacing is LATENCY+2 cycles when resp_ready is held at 1.
- req_valid seen while not in IDLE is ignored. The requester must hold the request until req_ready.
- resp_ready=0 stalls indefinitely in RESP; outputs are held.

## Test plan
- LATENCY=1, memory word 0x80FF_7F01 at 0x100.
  - lb at 0x101 -> resp_rdata=0x0000_007F.
  - lb at 0x102 -> 0xFFFF_FFFF.
  - lbu at 0x103 -> 0x0000_0080.
  - Each resp_valid appears 2 cycles after the handshake.
- sh data 0x0000_BEEF at 0x202 -> one cycle of mem_valid=1, mem_wen=1, mem_waddr=0x200, mem_wdata=0xBEEF_0000, mem_wmask=0x0C. Then resp_valid with rdata=0 and err=0.
- lw at 0x301, and separately req_size=3 -> no mem_valid pulse; resp_valid next cycle with resp_err=1 and resp_rdata=0.
- LATENCY=4, lw 0x400 with resp_ready=0 for 3 cycles -> mem_valid high exactly 4 cycles; resp_valid held stable until resp_ready; req_ready=0 until handshake.
- Reset asserted during a LATENCY=3 load's second ISSUE cycle -> mem_valid drops immediately, no resp_valid, req_ready=1. A following lw completes normally.
